// File: rtl/controle_cronometro.sv
// Stopwatch sequencing controller: debounces the four active-low buttons,
// runs the ZERADO/CONTANDO/VOLTA/PARADO state machine, makes the tenth tick
// and owns the elapsed-tenths counter and the (possibly frozen) display.
//
// Ports:
//   clk      system clock, everything on the rising edge
//   rst      synchronous active-high reset
//   btn1..4  start / lap / stop / clear, active-low, asynchronous
//   estado   current state (0 ZERADO, 1 CONTANDO, 2 VOLTA, 3 PARADO)
//   tick     one-cycle pulse per tenth while counting
//   wrap     one-cycle pulse when count rolls MAX_COUNT -> 0
//   count    elapsed tenths
//   display  value shown on the digits
//   hold     high while the display is frozen (VOLTA)

module controle_cronometro #(
   parameter int DEC_SEGUNDO = 5000000,
   parameter int DEBOUNCE    = 250000,
   parameter int MAX_COUNT   = 9999
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn1,
   input  logic        btn2,
   input  logic        btn3,
   input  logic        btn4,
   output logic [1:0]  estado,
   output logic        tick,
   output logic        wrap,
   output logic [13:0] count,
   output logic [13:0] display,
   output logic        hold
);

   localparam logic [1:0] ZERADO   = 2'd0;
   localparam logic [1:0] CONTANDO = 2'd1;
   localparam logic [1:0] VOLTA    = 2'd2;
   localparam logic [1:0] PARADO   = 2'd3;

   localparam int PW  = (DEC_SEGUNDO > 1) ? $clog2(DEC_SEGUNDO) : 1;
   localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   localparam logic [PW-1:0]  PMAX = PW'(DEC_SEGUNDO - 1);
   localparam logic [DBW-1:0] DMAX = DBW'(DEBOUNCE - 1);
   localparam logic [13:0]    CMAX = 14'(MAX_COUNT);

   // Index 0..3 = btn1..btn4
   logic [3:0] btn_n;
   logic [3:0] s1;
   logic [3:0] s2;
   logic [3:0] deb;
   logic [3:0] ev;
   logic [DBW-1:0] dcnt [4];

   assign btn_n = {btn4, btn3, btn2, btn1};

   // Level is accepted only after DEBOUNCE consecutive differing cycles;
   // any agreeing cycle restarts the count. The press event is raised on
   // the same edge the debounced level falls, so it is a registered pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1  <= 4'hF;
         s2  <= 4'hF;
         deb <= 4'hF;
         ev  <= 4'h0;
         for (int i = 0; i < 4; i++) dcnt[i] <= '0;
      end else begin
         s1 <= btn_n;
         s2 <= s1;
         for (int i = 0; i < 4; i++) begin
            ev[i] <= 1'b0;
            if (s2[i] != deb[i]) begin
               if (dcnt[i] == DMAX) begin
                  dcnt[i] <= '0;
                  deb[i]  <= s2[i];
                  ev[i]   <= deb[i];
               end else begin
                  dcnt[i] <= dcnt[i] + 1'b1;
               end
            end else begin
               dcnt[i] <= '0;
            end
         end
      end
   end

   // Only the highest-priority event of a cycle is acted on
   logic ev_clr;
   logic ev_stp;
   logic ev_lap;
   logic ev_sta;

   assign ev_clr = ev[3];
   assign ev_stp = ev[2] & ~ev[3];
   assign ev_lap = ev[1] & ~|ev[3:2];
   assign ev_sta = ev[0] & ~|ev[3:1];

   logic [1:0] nxt;

   always_comb begin
      nxt = estado;
      unique case (estado)
         ZERADO: begin
            if (ev_sta) nxt = CONTANDO;
         end
         CONTANDO: begin
            if (ev_clr)      nxt = ZERADO;
            else if (ev_stp) nxt = PARADO;
            else if (ev_lap) nxt = VOLTA;
         end
         VOLTA: begin
            if (ev_clr)      nxt = ZERADO;
            else if (ev_stp) nxt = PARADO;
            else if (ev_sta) nxt = CONTANDO;
         end
         PARADO: begin
            if (ev_clr)      nxt = ZERADO;
            else if (ev_sta) nxt = CONTANDO;
         end
         default: nxt = ZERADO;
      endcase
   end

   logic [PW-1:0] presc;
   logic          run;

   assign run  = (estado == CONTANDO) || (estado == VOLTA);
   assign tick = run && (presc == PMAX);
   assign hold = (estado == VOLTA);

   // Clearing wins over a coincident tick; PARADO simply holds presc so a
   // resume continues the current tenth instead of starting a new one.
   always_ff @(posedge clk) begin
      if (rst) begin
         estado  <= ZERADO;
         presc   <= '0;
         count   <= '0;
         display <= '0;
         wrap    <= 1'b0;
      end else begin
         estado <= nxt;
         wrap   <= 1'b0;
         if (nxt == ZERADO) begin
            presc   <= '0;
            count   <= '0;
            display <= '0;
         end else begin
            if (tick) begin
               presc <= '0;
               if (count == CMAX) begin
                  count <= '0;
                  wrap  <= 1'b1;
               end else begin
                  count <= count + 14'd1;
               end
            end else if (run) begin
               presc <= presc + 1'b1;
            end
            if (estado != VOLTA) display <= count;
         end
      end
   end

endmodule

// File: tb/tb_controle_cronometro.sv
// Directed bench for controle_cronometro (DEC_SEGUNDO=4, DEBOUNCE=3,
// MAX_COUNT=12); inputs driven and outputs sampled on the falling edge.

module tb_controle_cronometro;

   logic        clk;
   logic        rst;
   logic        btn1;
   logic        btn2;
   logic        btn3;
   logic        btn4;
   logic [1:0]  estado;
   logic        tick;
   logic        wrap;
   logic [13:0] count;
   logic [13:0] display;
   logic        hold;

   int checks;
   int failures;
   int cyc;
   int nticks;

   controle_cronometro #(
      .DEC_SEGUNDO(4),
      .DEBOUNCE(3),
      .MAX_COUNT(12)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn1(btn1),
      .btn2(btn2),
      .btn3(btn3),
      .btn4(btn4),
      .estado(estado),
      .tick(tick),
      .wrap(wrap),
      .count(count),
      .display(display),
      .hold(hold)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic go(input int t);
      while (cyc < t) step(1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_estado"}, 32'(estado), 0);
      chk({tag, "_tick"}, 32'(tick), 0);
      chk({tag, "_wrap"}, 32'(wrap), 0);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_display"}, 32'(display), 0);
      chk({tag, "_hold"}, 32'(hold), 0);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      nticks = 0;
      rst = 1'b1;
      btn1 = 1'b1;
      btn2 = 1'b1;
      btn3 = 1'b1;
      btn4 = 1'b1;
      step(3);
      chk_reset("rst0");
      rst = 1'b0;
      step(2);

      // Two-cycle glitch must be rejected
      btn1 = 1'b0;
      step(2);
      btn1 = 1'b1;
      step(10);
      chk("glitch_estado", 32'(estado), 0);
      chk("glitch_count", 32'(count), 0);
      step(10);

      // Start: cyc 0 is the drive point of btn1
      cyc = 0;
      btn1 = 1'b0;
      go(5);
      chk("start_pre", 32'(estado), 0);
      go(6);
      chk("start_estado", 32'(estado), 1);
      chk("start_count", 32'(count), 0);
      go(8);
      chk("tick_pre", 32'(tick), 0);
      go(9);
      chk("tick_first", 32'(tick), 1);
      chk("tick_cnt0", 32'(count), 0);
      go(10);
      btn1 = 1'b1;
      chk("cnt1", 32'(count), 1);
      chk("disp_lag0", 32'(display), 0);
      chk("tick_off", 32'(tick), 0);
      go(11);
      chk("disp_lag1", 32'(display), 1);
      go(14);
      chk("cnt2", 32'(count), 2);

      // Lap at count 5
      go(22);
      btn2 = 1'b0;
      go(27);
      chk("lap_pre", 32'(estado), 1);
      go(28);
      chk("lap_estado", 32'(estado), 2);
      chk("lap_hold", 32'(hold), 1);
      chk("lap_disp", 32'(display), 5);
      go(32);
      btn2 = 1'b1;
      go(42);
      chk("lap_cnt9", 32'(count), 9);
      chk("lap_disp9", 32'(display), 5);
      btn1 = 1'b0;
      go(48);
      chk("resume_estado", 32'(estado), 1);
      chk("resume_hold", 32'(hold), 0);
      chk("resume_disp0", 32'(display), 5);
      go(49);
      chk("resume_cnt", 32'(count), 10);
      chk("resume_disp", 32'(display), 10);

      // Wrap at MAX_COUNT
      go(52);
      btn1 = 1'b1;
      go(54);
      chk("cnt12", 32'(count), 12);
      go(57);
      chk("wrap_pre", 32'(wrap), 0);
      chk("wrap_tick", 32'(tick), 1);
      go(58);
      chk("wrap_pulse", 32'(wrap), 1);
      chk("wrap_cnt", 32'(count), 0);
      go(59);
      chk("wrap_once", 32'(wrap), 0);
      chk("wrap_disp", 32'(display), 0);

      // Stop with the prescaler mid-tenth
      go(61);
      btn3 = 1'b0;
      go(67);
      chk("stop_estado", 32'(estado), 3);
      chk("stop_cnt", 32'(count), 2);
      go(71);
      btn3 = 1'b1;
      while (cyc < 117) begin
         step(1);
         if (tick) nticks++;
      end
      chk("stop_ticks", 32'(nticks), 0);
      chk("stop_frozen", 32'(count), 2);
      chk("stop_estado2", 32'(estado), 3);
      btn1 = 1'b0;
      go(123);
      chk("run2_estado", 32'(estado), 1);
      go(124);
      chk("phase_notick", 32'(tick), 0);
      go(125);
      chk("phase_tick", 32'(tick), 1);
      go(126);
      chk("phase_cnt", 32'(count), 3);

      // Lap and clear together: clear wins
      go(127);
      btn1 = 1'b1;
      go(130);
      btn2 = 1'b0;
      btn4 = 1'b0;
      go(135);
      chk("clr_pre", 32'(estado), 1);
      chk("clr_pre_cnt", 32'(count), 5);
      go(136);
      chk("clr_estado", 32'(estado), 0);
      chk("clr_cnt", 32'(count), 0);
      chk("clr_disp", 32'(display), 0);
      chk("clr_hold", 32'(hold), 0);
      go(140);
      btn2 = 1'b1;
      btn4 = 1'b1;

      // Reset while in VOLTA at count 3
      go(150);
      btn1 = 1'b0;
      go(160);
      btn1 = 1'b1;
      btn2 = 1'b0;
      go(166);
      chk("v2_estado", 32'(estado), 2);
      chk("v2_disp", 32'(display), 2);
      go(168);
      chk("v2_cnt", 32'(count), 3);
      btn2 = 1'b1;
      rst = 1'b1;
      go(169);
      chk_reset("rst1");
      rst = 1'b0;
      go(180);
      chk("post_rst", 32'(estado), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
